// File: rtl/bus_pkg.sv
// Shared definitions for the snooping bus arbiter and the cache controllers.
// Holds the bus function and line-state encodings, the arbiter state enum
// and a one-hot decode helper used to build grant vectors.
package bus_pkg;

  localparam int MAX_N   = 8;
  localparam int MAX_IDW = 3;

  typedef enum logic [1:0] {
    P_READ  = 2'b00,
    P_WRITE = 2'b01,
    B_READ  = 2'b10,
    B_WRITE = 2'b11
  } bus_func_e;

  typedef enum logic [1:0] {
    INVL = 2'b00,
    SHRD = 2'b10,
    EXCL = 2'b11
  } line_state_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_XFER    = 2'b01,
    ST_RELEASE = 2'b10
  } arb_state_e;

  // One-hot decode sized for the largest supported cache count; callers
  // truncate the result to their own N.
  function automatic logic [MAX_N-1:0] onehot(input logic [MAX_IDW-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin winner selection, purely combinational.
// Ports:
//   req   - request vector, one bit per cache
//   ptr   - index that has highest priority this round
//   valid - at least one request is present
//   idx   - first requesting index found scanning upward from ptr with wrap
module rr_picker #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           valid,
  output logic [IDW-1:0] idx
);

  always_comb begin
    int   w_j;
    logic w_found;
    w_j     = 0;
    w_found = 1'b0;
    valid   = |req;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      w_j = (int'(ptr) + k) % N;
      if (!w_found && req[w_j[IDW-1:0]]) begin
        idx     = w_j[IDW-1:0];
        w_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/snoop_bus_arbiter.sv
// Round-robin arbiter and sequencer for the shared snooping bus.
// Grants the bus to one cache controller at a time, drives the memory
// strobes for the owner's latched bus function, broadcasts snoop requests to
// the non-owners and ends each tenure on completion, requester drop or
// watchdog expiry.
// Ports:
//   clk, reset                  - bus clock, asynchronous active-low reset
//   bus_req[N], bus_func[2N]    - per-cache request and 2-bit function
//   mem_ready                   - memory access complete
//   snoop_hit_in, snoop_ready_in- per-cache snoop responses
//   bus_gnt[N], gnt_id          - registered one-hot grant and owner index
//   mem_cs, mem_rd, mem_wr      - memory strobes (combinational)
//   snoop_req[N]                - snoop broadcast to non-owners
//   snoop_hit, snoop_ready      - OR of non-owner responses, to the owner
//   busy, timeout_err           - registered status, one-cycle abort pulse
module snoop_bus_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         bus_req,
  input  logic [2*N-1:0]       bus_func,
  input  logic                 mem_ready,
  input  logic [N-1:0]         snoop_hit_in,
  input  logic [N-1:0]         snoop_ready_in,
  output logic [N-1:0]         bus_gnt,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 mem_cs,
  output logic                 mem_rd,
  output logic                 mem_wr,
  output logic [N-1:0]         snoop_req,
  output logic                 snoop_hit,
  output logic                 snoop_ready,
  output logic                 busy,
  output logic                 timeout_err
);

  import bus_pkg::*;

  localparam int IDW = $clog2(N);
  localparam int WDW = 16;
  localparam logic [IDW-1:0] LAST_ID = IDW'(N - 1);

  arb_state_e     r_state;
  arb_state_e     w_state_nxt;
  bus_func_e      r_func;
  logic [IDW-1:0] r_id;
  logic [IDW-1:0] r_ptr;
  logic [WDW-1:0] r_wdog;
  logic [N-1:0]   r_gnt;
  logic           r_busy;
  logic           r_tmo;

  logic           w_pick_valid;
  logic [IDW-1:0] w_pick_idx;
  logic [1:0]     w_func_sel;
  logic [N-1:0]   w_other;
  logic           w_xfer;
  logic           w_hit;
  logic           w_rdy;
  logic           w_done;
  logic           w_drop;
  logic           w_expire;
  logic           w_grant;
  logic           w_exit;
  logic           w_tmo_evt;

  rr_picker #(
    .N   (N),
    .IDW (IDW)
  ) u_picker (
    .req   (bus_req),
    .ptr   (r_ptr),
    .valid (w_pick_valid),
    .idx   (w_pick_idx)
  );

  assign w_func_sel = bus_func[{w_pick_idx, 1'b0} +: 2];
  assign w_xfer     = (r_state == ST_XFER);
  // r_gnt holds exactly the owner bit during XFER, so its complement is the
  // set of snooping caches.
  assign w_other    = ~r_gnt;
  assign w_hit      = w_xfer & (|(snoop_hit_in & w_other));
  assign w_rdy      = w_xfer & (|(snoop_ready_in & w_other));
  assign w_drop     = ~bus_req[r_id];
  // The watchdog is loaded with TIMEOUT on grant and counts XFER cycles, so
  // a value of 1 marks the last cycle the tenure is allowed.
  assign w_expire   = (r_wdog <= WDW'(1));

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_exit      = 1'b0;
    w_tmo_evt   = 1'b0;
    w_done      = 1'b0;
    mem_cs      = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    snoop_req   = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_valid) begin
          w_grant     = 1'b1;
          w_state_nxt = ST_XFER;
        end
      end
      ST_XFER: begin
        case (r_func)
          B_WRITE: begin
            mem_cs = 1'b1;
            mem_wr = 1'b1;
            w_done = mem_ready;
          end
          B_READ: begin
            // A snoop hit means a peer supplies the line, so memory is
            // deselected and the tenure waits for the peer instead.
            mem_cs    = ~w_hit;
            mem_rd    = 1'b1;
            snoop_req = w_other;
            w_done    = w_hit ? w_rdy : mem_ready;
          end
          P_WRITE: begin
            snoop_req = w_other;
            w_done    = 1'b1;
          end
          default: w_done = 1'b1;
        endcase
        if (w_done || w_drop || w_expire) begin
          w_exit      = 1'b1;
          w_tmo_evt   = ~w_done & ~w_drop;
          w_state_nxt = ST_RELEASE;
        end
      end
      ST_RELEASE: w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_func <= P_READ;
      r_id   <= '0;
      r_ptr  <= '0;
      r_wdog <= '0;
      r_gnt  <= '0;
      r_busy <= 1'b0;
      r_tmo  <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != ST_IDLE);
      r_tmo  <= w_tmo_evt;
      if (w_grant) begin
        r_id   <= w_pick_idx;
        r_func <= bus_func_e'(w_func_sel);
        r_wdog <= WDW'(TIMEOUT);
        r_gnt  <= N'(onehot(MAX_IDW'(w_pick_idx)));
      end else if (w_xfer) begin
        r_wdog <= r_wdog - 1'b1;
        if (w_exit) begin
          r_gnt <= '0;
          r_ptr <= (r_id == LAST_ID) ? '0 : r_id + 1'b1;
        end
      end
    end
  end

  assign bus_gnt     = r_gnt;
  assign gnt_id      = r_id;
  assign snoop_hit   = w_hit;
  assign snoop_ready = w_rdy;
  assign busy        = r_busy;
  assign timeout_err = r_tmo;

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Self-checking bench for snoop_bus_arbiter: directed scenarios followed by
// randomized traffic, all compared against a tenure-level reference model.
module tb_snoop_bus_arbiter;

  localparam int N   = 4;
  localparam int TMO = 8;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   bus_req;
  logic [2*N-1:0] bus_func;
  logic           mem_ready;
  logic [N-1:0]   snoop_hit_in;
  logic [N-1:0]   snoop_ready_in;
  logic [N-1:0]   bus_gnt;
  logic [1:0]     gnt_id;
  logic           mem_cs, mem_rd, mem_wr;
  logic [N-1:0]   snoop_req;
  logic           snoop_hit, snoop_ready, busy, timeout_err;

  snoop_bus_arbiter #(.N(N), .TIMEOUT(TMO)) dut (
    .clk            (clk),
    .reset          (reset),
    .bus_req        (bus_req),
    .bus_func       (bus_func),
    .mem_ready      (mem_ready),
    .snoop_hit_in   (snoop_hit_in),
    .snoop_ready_in (snoop_ready_in),
    .bus_gnt        (bus_gnt),
    .gnt_id         (gnt_id),
    .mem_cs         (mem_cs),
    .mem_rd         (mem_rd),
    .mem_wr         (mem_wr),
    .snoop_req      (snoop_req),
    .snoop_hit      (snoop_hit),
    .snoop_ready    (snoop_ready),
    .busy           (busy),
    .timeout_err    (timeout_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: who owns the bus, for how many cycles, and whether the
  // current cycle is the single dead cycle after a tenure.
  int         m_owner;
  int         m_ptr;
  int         m_last;
  int         m_age;
  logic [1:0] m_func;
  bit         m_rel;
  bit         m_tmo;

  logic [N-1:0] gnt_log[$];
  int           gnt_at[$];
  logic [N-1:0] prev_gnt;
  logic [N-1:0] watch_gnt;
  int           cyc, gnt_hi, tmo_cnt;
  logic [N-1:0] rr_exp[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] m_mask();
    return (m_owner >= 0) ? N'(1 << m_owner) : '0;
  endfunction

  function automatic bit model_done();
    logic [N-1:0] oth;
    bit h, r;
    oth = ~m_mask();
    h   = |(snoop_hit_in & oth);
    r   = |(snoop_ready_in & oth);
    case (m_func)
      2'b11:   return mem_ready;
      2'b10:   return h ? r : mem_ready;
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_last = 0; m_age = 0;
    m_func = 2'b00; m_rel = 0; m_tmo = 0;
  endtask

  task automatic model_edge();
    bit done, held;
    int j;
    m_tmo = 0;
    if (m_owner >= 0) begin
      done = model_done();
      held = bus_req[m_owner];
      if (done || !held || m_age >= TMO) begin
        m_tmo   = !done && held;
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_rel   = 1;
      end else begin
        m_age++;
      end
    end else if (m_rel) begin
      m_rel = 0;
    end else if (bus_req != '0) begin
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (bus_req[j]) begin
          m_owner = j;
          break;
        end
      end
      m_func = bus_func[2*m_owner +: 2];
      m_age  = 1;
      m_last = m_owner;
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] om, oth, sreq;
    logic eh, er, cs, rd, wr;
    om   = m_mask();
    oth  = (m_owner >= 0) ? ~om : '0;
    eh   = |(snoop_hit_in & oth);
    er   = |(snoop_ready_in & oth);
    cs = 0; rd = 0; wr = 0; sreq = '0;
    if (m_owner >= 0) begin
      case (m_func)
        2'b11:   begin cs = 1; wr = 1; end
        2'b10:   begin cs = !eh; rd = 1; sreq = oth; end
        2'b01:   sreq = oth;
        default: ;
      endcase
    end
    check_val("bus_gnt",     32'(bus_gnt),     32'(om));
    check_val("gnt_id",      32'(gnt_id),      m_last);
    check_val("busy",        32'(busy),        32'(m_owner >= 0 || m_rel));
    check_val("timeout_err", 32'(timeout_err), 32'(m_tmo));
    check_val("mem_cs",      32'(mem_cs),      32'(cs));
    check_val("mem_rd",      32'(mem_rd),      32'(rd));
    check_val("mem_wr",      32'(mem_wr),      32'(wr));
    check_val("snoop_req",   32'(snoop_req),   32'(sreq));
    check_val("snoop_hit",   32'(snoop_hit),   32'(eh));
    check_val("snoop_ready", 32'(snoop_ready), 32'(er));
  endtask

  // Called at a falling edge with inputs already driven for this cycle.
  task automatic cycle();
    #1;
    check_outputs();
    if (bus_gnt != '0 && prev_gnt == '0) begin
      gnt_log.push_back(bus_gnt);
      gnt_at.push_back(cyc);
    end
    if (bus_gnt == watch_gnt) gnt_hi++;
    if (timeout_err) tmo_cnt++;
    prev_gnt = bus_gnt;
    cyc++;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic clear_log(input logic [N-1:0] w);
    gnt_log.delete();
    gnt_at.delete();
    gnt_hi = 0; tmo_cnt = 0; cyc = 0;
    watch_gnt = w;
    prev_gnt  = '0;
  endtask

  task automatic idle_inputs();
    bus_req = '0; bus_func = '0; mem_ready = 0;
    snoop_hit_in = '0; snoop_ready_in = '0;
  endtask

  task automatic do_reset();
    reset = 0;
    idle_inputs();
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    reset = 1;
  endtask

  initial begin
    idle_inputs();
    #2;
    do_reset();

    // Single b_write request, memory ready on the third XFER cycle.
    clear_log(4'b0001);
    bus_req = 4'b0001; bus_func = 8'b0000_0011;
    cycle();
    #1;
    check_val("single_cs_wr", 32'({mem_cs, mem_wr}), 32'b11);
    cycle(); cycle();
    mem_ready = 1; cycle();
    mem_ready = 0; bus_req = '0; cycle(); cycle();
    check_val("single_gnt_cycles", gnt_hi, 3);
    check_val("single_gnt_count", gnt_log.size(), 1);

    // Round robin over four held p_read requests.
    do_reset();
    clear_log(4'b0001);
    bus_req = 4'b1111;
    repeat (16) cycle();
    for (int k = 0; k < 5; k++)
      check_val($sformatf("rr_gnt%0d", k),
                32'((gnt_log.size() > k) ? gnt_log[k] : '0), 32'(rr_exp[k]));
    for (int k = 0; k < 4; k++)
      check_val($sformatf("rr_spacing%0d", k),
                (gnt_at.size() > k + 1) ? gnt_at[k+1] - gnt_at[k] : -1, 3);
    bus_req = '0; cycle(); cycle(); cycle();

    // Snoop hit: cache1 b_read, cache2 hits and supplies data two cycles later.
    do_reset();
    clear_log(4'b0010);
    bus_req = 4'b0010; bus_func = 8'b0000_1000;
    snoop_hit_in = 4'b0100; mem_ready = 1;
    cycle();
    #1;
    check_val("hit_snoop_req", 32'(snoop_req), 32'b1101);
    check_val("hit_cs_rd", 32'({mem_cs, mem_rd}), 32'b01);
    check_val("hit_snoop_hit", 32'(snoop_hit), 1);
    cycle(); cycle();
    snoop_ready_in = 4'b0100; cycle();
    idle_inputs(); cycle(); cycle();
    check_val("hit_gnt_cycles", gnt_hi, 3);

    // Snoop miss: memory supplies; bus_func change mid-tenure must be ignored.
    do_reset();
    clear_log(4'b0010);
    bus_req = 4'b0010; bus_func = 8'b0000_1000;
    cycle();
    #1;
    check_val("miss_cs_rd", 32'({mem_cs, mem_rd}), 32'b11);
    bus_func = 8'b0000_0100;
    cycle(); cycle();
    mem_ready = 1; cycle();
    idle_inputs(); cycle(); cycle();
    check_val("miss_gnt_cycles", gnt_hi, 3);

    // Watchdog abort: b_write with no mem_ready, then the pointer moves on.
    do_reset();
    clear_log(4'b0001);
    bus_req = 4'b0011; bus_func = 8'b0000_1111;
    repeat (14) cycle();
    check_val("tmo_gnt_cycles", gnt_hi, TMO);
    check_val("tmo_pulses", tmo_cnt, 1);
    check_val("tmo_next_gnt", 32'((gnt_log.size() > 1) ? gnt_log[1] : '0), 32'b0010);

    // Reset in the middle of a tenure.
    do_reset();
    bus_req = 4'b0001; bus_func = 8'b0000_0011;
    cycle(); cycle();
    #2;
    reset = 0;
    #1;
    check_val("rst_gnt", 32'(bus_gnt), 0);
    check_val("rst_strobes", 32'({mem_cs, mem_rd, mem_wr}), 0);
    check_val("rst_busy", 32'(busy), 0);
    model_reset();
    @(negedge clk);
    reset = 1;
    clear_log(4'b1000);
    bus_req = 4'b1000; bus_func = '0;
    cycle(); cycle();
    bus_req = '0; cycle(); cycle();
    check_val("rst_regrant", 32'((gnt_log.size() > 0) ? gnt_log[0] : '0), 32'b1000);
    check_val("rst_gnt_id", 32'(gnt_id), 3);

    // Randomized traffic.
    do_reset();
    clear_log(4'b0001);
    for (int c = 0; c < 1500; c++) begin
      if (m_rel && $urandom_range(0, 1) == 0) bus_req[m_last] = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!bus_req[i]) bus_req[i] = ($urandom_range(0, 2) == 0);
        else if (i == m_owner && $urandom_range(0, 11) == 0) bus_req[i] = 1'b0;
      end
      bus_func       = 8'($urandom);
      mem_ready      = ($urandom_range(0, 3) == 0);
      snoop_hit_in   = N'($urandom) & N'($urandom);
      snoop_ready_in = N'($urandom);
      cycle();
    end
    idle_inputs();
    repeat (4) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/snoop_bus_arbiter.md
# snoop_bus_arbiter

Round-robin arbiter and sequencer for the shared snooping bus and main-memory port used by N `cache_controller` instances. It grants the bus to one cache at a time, drives the memory chip-select/read/write strobes for the granted bus function, and broadcasts snoop requests to the non-owner caches. It also returns the combined snoop hit/ready to the owner and ends the tenure on the same completion conditions the cache controllers use.

## Interface
- N, default 4: number of cache controllers (2..8).
- TIMEOUT, default 255: maximum cycles one tenure may last before a forced abort (1..65535).
- clk  in  1  bus clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; forces all state and outputs to reset values.
- bus_req  in  N  bit i = cache i requests the bus; held until its grant completes.
- bus_func  in  2*N  function of cache i at bits [2i+1:2i]; encodings p_read 00, p_write 01, b_read 10, b_write 11.
- mem_ready  in  1  memory access complete.
- snoop_hit_in  in  N  bit i = cache i holds the snooped line.
- snoop_ready_in  in  N  bit i = cache i has placed snoop data on the bus.
- bus_gnt  out  N  one-hot grant (all zero when no owner).
- gnt_id  out  clog2(N)  index of the current or most recent owner.
- mem_cs, mem_rd, mem_wr  out  1 each  memory strobes.
- snoop_req  out  N  snoop broadcast; never asserted to the owner.
- snoop_hit, snoop_ready  out  1 each  OR of the non-owner snoop_hit_in / snoop_ready_in, to the owner.
- busy  out  1  high in every state except IDLE.
- timeout_err  out  1  one-cycle pulse on a forced abort.

## Operation
- States: IDLE, XFER, RELEASE.
- IDLE: if bus_req != 0, pick the winner starting at index ptr and going upward with wrap. Latch id and func, load the watchdog with TIMEOUT, then go to XFER.
- XFER: bus_gnt[id]=1. Outputs by latched func:
  - b_write: mem_cs=1, mem_wr=1; complete on mem_ready.
  - b_read: mem_cs=!snoop_hit, mem_rd=1, snoop_req=~gnt; complete on (snoop_hit && snoop_ready) || (!snoop_hit && mem_ready).
  - p_write: snoop_req=~gnt for one cycle as an invalidate; complete immediately.
  - p_read: no strobes; complete immediately.
- On complete, go to RELEASE and set ptr = (id+1) mod N.
- Abort conditions in XFER:
  - bus_req[id] drops: go to RELEASE; ptr is updated and no error is flagged.
  - Watchdog reaches 0: go to RELEASE, pulse timeout_err, and update ptr.
- RELEASE: all strobes and grants are low; go to IDLE unconditionally.
- Priority when events coincide in the same cycle: completion, then requester drop, then timeout.
- Only the latched func is used during a tenure; changes to bus_func during XFER are ignored.
- Reset values: bus_gnt=0, gnt_id=0, ptr=0, watchdog=0, state IDLE, all 1-bit outputs 0. Reset mid-tenure drops the grant asynchronously; no completion is signalled.

## Timing
- bus_req sampled high in IDLE at edge t gives bus_gnt high from t+1.
- bus_gnt, gnt_id, busy and timeout_err are registered.
- Strobes, snoop_req, snoop_hit and snoop_ready are combinational from state, the latched func and the inputs; they are valid in the same cycle as bus_gnt.
- A completion input seen at edge t makes bus_gnt low from t+1.
- Back-to-back tenures have exactly 2 cycles with bus_gnt=0 (RELEASE, IDLE).
- The watchdog decrements every XFER cycle. A tenure lasts at most TIMEOUT cycles.

## Structure
- bus_pkg holds:
  - func encodings (p_read, p_write, b_read, b_write)
  - line-state encodings (excl 11, shrd 10, invl 00)
  - the arbiter state enum
  - the function `onehot(idx)`
- Sub-module rr_picker: purely combinational; inputs req[N] and ptr; outputs valid and idx.

## Test plan
- Single request: bus_req=0001, func b_write, mem_ready after 3 cycles -> gnt=0001 for 3 cycles, mem_cs=mem_wr=1 until mem_ready, then RELEASE, then IDLE.
- Round robin: bus_req=1111 held, each tenure p_read -> grants go 0001, 0010, 0100, 1000, 0001, with a 2-cycle gap between each.
- Snoop hit: cache1 owns with b_read, snoop_hit_in=0100, snoop_ready_in=0100 two cycles later -> snoop_req=1101, mem_cs=0, mem_rd=1; tenure ends when snoop_ready arrives.
- Snoop miss: b_read, snoop_hit_in=0 -> mem_cs=mem_rd=1; tenure ends on mem_ready.
- Timeout: TIMEOUT=8, b_write, mem_ready never asserted -> after 8 XFER cycles timeout_err pulses once, gnt drops, and ptr advances.
- Reset mid-XFER -> bus_gnt=0 and all strobes 0 immediately; after reset releases, bus_req=1000 is granted from IDLE with ptr=0.
